// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: request/address from fetch, ready/data back from memory.
interface instr_fetch_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequences the PC, fetches over a req/ready bus and
// presents one instruction per cycle to decode, honouring redirect, stall and halt.
module instr_fetch #(
  parameter int unsigned   PC_W     = 16,
  parameter int unsigned   INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_sys,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [3:0]         func,
  output logic [PC_W-1:0]    instr_pc,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(2);
  localparam logic [PC_W-1:0] HALF_MSK = ~PC_W'(1);

  typedef enum logic [1:0] {START, RUN, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic            slot_free_c;
  logic            fetch_c;

  assign slot_free_c = !instr_valid || !stall;

  // Request is combinational so decode back-pressure and redirects act in the same cycle.
  always_comb begin
    fetch_c = 1'b0;
    if (state == RUN) begin
      fetch_c = slot_free_c && !redirect && !halt_sys;
    end
  end

  assign imem.imem_req  = fetch_c;
  assign imem.imem_addr = pc;
  assign opcode         = instr[INSTR_W-1 -: 4];
  assign func           = instr[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      pc          <= RESET_PC & HALF_MSK;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        START: state <= RUN;
        RUN: begin
          if (halt_sys) begin
            // Freeze with pc/instr intact; the halting instruction is never replaced.
            state       <= HALTED;
            halted      <= 1'b1;
            instr_valid <= 1'b0;
          end else if (redirect) begin
            pc          <= redirect_pc & HALF_MSK;
            instr_valid <= 1'b0;
          end else if (slot_free_c) begin
            if (imem.imem_ready) begin
              instr       <= imem.imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_STEP;
            end else begin
              instr_valid <= 1'b0;
            end
          end
        end
        HALTED: begin
          halted      <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory returns addr + 0x1000 as the word at each address.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_sys;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic [15:0] instr_pc;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  instr_fetch_if #(.PC_W(16), .INSTR_W(16)) imem ();

  instr_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0010)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_sys   (halt_sys),
    .instr_valid(instr_valid),
    .instr      (instr),
    .opcode     (opcode),
    .func       (func),
    .instr_pc   (instr_pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem.imem_rdata = imem.imem_ready ? (imem.imem_addr + 16'h1000) : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt_sys    = 1'b0;
    imem.imem_ready = 1'b1;
    #12;
    check_eq("rst_req",    32'(imem.imem_req), 32'd0);
    check_eq("rst_valid",  32'(instr_valid), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_instr",  32'(instr), 32'h0);
    check_eq("rst_ipc",    32'(instr_pc), 32'h0);
    check_eq("rst_addr",   32'(imem.imem_addr), 32'h0010);

    // Reset release: START cycle issues no request.
    rst_n = 1'b1;
    #1;
    check_eq("start_req", 32'(imem.imem_req), 32'd0);
    tick();
    check_eq("run_req",   32'(imem.imem_req), 32'd1);
    check_eq("run_addr",  32'(imem.imem_addr), 32'h0010);
    check_eq("run_valid", 32'(instr_valid), 32'd0);
    tick();
    check_eq("f0_valid",  32'(instr_valid), 32'd1);
    check_eq("f0_ipc",    32'(instr_pc), 32'h0010);
    check_eq("f0_instr",  32'(instr), 32'h1010);
    check_eq("f0_opcode", 32'(opcode), 32'h1);
    check_eq("f0_func",   32'(func), 32'h0);
    check_eq("f0_addr",   32'(imem.imem_addr), 32'h0012);
    tick();
    check_eq("f1_valid", 32'(instr_valid), 32'd1);
    check_eq("f1_ipc",   32'(instr_pc), 32'h0012);
    tick();
    check_eq("f2_valid", 32'(instr_valid), 32'd1);
    check_eq("f2_ipc",   32'(instr_pc), 32'h0014);

    // Wait states at 0x0004.
    redirect = 1'b1; redirect_pc = 16'h0004;
    #1;
    check_eq("rd4_req", 32'(imem.imem_req), 32'd0);
    tick();
    redirect = 1'b0; imem.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("ws_addr",  32'(imem.imem_addr), 32'h0004);
      check_eq("ws_req",   32'(imem.imem_req), 32'd1);
      check_eq("ws_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    imem.imem_ready = 1'b1;
    #1;
    check_eq("ws_addr4",  32'(imem.imem_addr), 32'h0004);
    check_eq("ws_valid4", 32'(instr_valid), 32'd0);
    tick();
    check_eq("ws_done_valid", 32'(instr_valid), 32'd1);
    check_eq("ws_done_ipc",   32'(instr_pc), 32'h0004);
    check_eq("ws_done_instr", 32'(instr), 32'h1004);

    // Stall holding 0x1234.
    redirect = 1'b1; redirect_pc = 16'h0234;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("st_instr", 32'(instr), 32'h1234);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("st_req",   32'(imem.imem_req), 32'd0);
      check_eq("st_hold",  32'(instr), 32'h1234);
      check_eq("st_valid", 32'(instr_valid), 32'd1);
      check_eq("st_ipc",   32'(instr_pc), 32'h0234);
      tick();
    end
    stall = 1'b0;
    #1;
    check_eq("st_resume_req",  32'(imem.imem_req), 32'd1);
    check_eq("st_resume_addr", 32'(imem.imem_addr), 32'h0236);
    tick();
    check_eq("st_next_ipc",   32'(instr_pc), 32'h0236);
    check_eq("st_next_instr", 32'(instr), 32'h1236);

    // Redirect wins over stall; odd target is aligned.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0101;
    #1;
    check_eq("rs_req", 32'(imem.imem_req), 32'd0);
    tick();
    stall = 1'b0; redirect = 1'b0;
    #1;
    check_eq("rs_valid", 32'(instr_valid), 32'd0);
    check_eq("rs_addr",  32'(imem.imem_addr), 32'h0100);
    check_eq("rs_req1",  32'(imem.imem_req), 32'd1);
    tick();
    check_eq("rs_ipc", 32'(instr_pc), 32'h0100);

    // PC wrap.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("wr_ipc0", 32'(instr_pc), 32'hFFFE);
    check_eq("wr_addr", 32'(imem.imem_addr), 32'h0000);
    tick();
    check_eq("wr_ipc1",   32'(instr_pc), 32'h0000);
    check_eq("wr_instr1", 32'(instr), 32'h1000);

    // Halt beats redirect and is permanent.
    halt_sys = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    #1;
    check_eq("h_req0", 32'(imem.imem_req), 32'd0);
    tick();
    halt_sys = 1'b0; redirect_pc = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      redirect = i[0];
      #1;
      check_eq("h_halted", 32'(halted), 32'd1);
      check_eq("h_valid",  32'(instr_valid), 32'd0);
      check_eq("h_req",    32'(imem.imem_req), 32'd0);
      check_eq("h_addr",   32'(imem.imem_addr), 32'h0002);
      check_eq("h_instr",  32'(instr), 32'h1000);
      tick();
    end
    redirect = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("hr_halted", 32'(halted), 32'd0);
    check_eq("hr_valid",  32'(instr_valid), 32'd0);
    check_eq("hr_req",    32'(imem.imem_req), 32'd0);
    check_eq("hr_addr",   32'(imem.imem_addr), 32'h0010);
    check_eq("hr_instr",  32'(instr), 32'h0);
    check_eq("hr_ipc",    32'(instr_pc), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("hr_restart_ipc",   32'(instr_pc), 32'h0010);
    check_eq("hr_restart_valid", 32'(instr_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits upstream of the main control decoder. It sequences the program counter, issues word requests to instruction memory through a req/ready handshake, and presents one instruction (with its opcode and func fields split out) per cycle to decode. It reacts to branch/jump redirects and pipeline stalls, and it freezes permanently when the control decoder raises `halt_sys` on a HALT, an unknown opcode, divide-by-zero or overflow.

## Interface
- `PC_W`, 16, program counter / instruction-address width (byte address).
- `INSTR_W`, 16, instruction width; opcode = `instr[15:12]`, func = `instr[3:0]`.
- `RESET_PC`, 16'h0000, PC loaded on reset; bit 0 must be 0.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out PC_W: fetch byte address, equal to the current PC.
- `imem_ready` in 1: memory accepts and returns data this cycle.
- `imem_rdata` in INSTR_W: instruction word, valid when `imem_req && imem_ready`.
- `stall` in 1: decode cannot accept; hold the presented instruction.
- `redirect` in 1: taken branch or jump; squash and refetch.
- `redirect_pc` in PC_W: target address; bit 0 is forced to 0.
- `halt_sys` in 1: halt from the control decoder.
- `instr_valid` out 1: `instr` holds a live instruction.
- `instr` out INSTR_W: instruction register (IF/ID).
- `opcode` out 4: `instr[15:12]`.
- `func` out 4: `instr[3:0]`.
- `instr_pc` out PC_W: address `instr` was fetched from.
- `halted` out 1: fetch is frozen.

## Operation
- States:
  - START: reset state, no request.
  - RUN: normal fetching.
  - HALTED: terminal; left only by reset.
- START → RUN unconditionally after one cycle.
- Slot free = `!instr_valid || !stall`.
- In RUN, `imem_req = slot_free && !redirect && !halt_sys`, combinational.
- Handshake:
  - A transfer completes only in a cycle with `imem_req && imem_ready`.
  - `req` may drop without a transfer; there are no outstanding requests.
  - `imem_addr` is stable while `req` is held.
- On transfer:
  - `instr <= imem_rdata`, `instr_pc <= pc`, `instr_valid <= 1`.
  - `pc <= pc + 2`, modulo 2^PC_W, so 0xFFFE wraps to 0x0000.
- Slot free with no transfer: `instr_valid <= 0`.
- `stall` with `instr_valid`: `instr`, `instr_pc` and `instr_valid` hold; no request is issued.
- `redirect` (RUN, no halt):
  - `pc <= {redirect_pc[PC_W-1:1],1'b0}`, `instr_valid <= 0`.
  - No request is issued that cycle; `stall` is ignored.
- `halt_sys` in RUN:
  - Next state HALTED, `instr_valid <= 0`, `imem_req = 0` that cycle.
  - `pc` and `instr` hold their values.
- Priority: `halt_sys` > `redirect` > `stall` > normal fetch.
- HALTED:
  - `imem_req = 0`, `instr_valid = 0`, `halted = 1`.
  - All inputs except `rst_n` are ignored.
- `opcode`/`func` are pure slices of `instr`; they are meaningful only when `instr_valid = 1`.

## Timing
- Reset values (asynchronous): state START, `pc = RESET_PC`, `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `halted = 0`, `imem_req = 0`.
- First `imem_req` is in the first cycle after the first rising edge following `rst_n` deassertion.
- Latency: a transfer in cycle N gives `instr_valid = 1` in N+1.
- Zero-wait memory gives one instruction per cycle.
- Wait states: `req` is held at the same address until `ready`; `instr_valid` is 0 for each cycle with no transfer.
- Redirect in cycle N:
  - `instr_valid = 0` in N+1.
  - First request to the target is issued in N+1.
  - Target instruction is valid in N+2 at earliest.
- `halt_sys` in cycle N: `halted = 1` and `instr_valid = 0` from N+1.
  - The instruction that caused the halt is not replaced.
  - Nothing after it is ever presented.
- Reset asserted mid-transfer or in HALTED: immediate return to reset values; any partial fetch is abandoned.
- `rst_n` deassertion must be synchronised externally to `clk`.

## Test plan
- Reset with RESET_PC=0x0010 and `ready` tied 1 → `req` first rises one cycle after reset release; `instr_pc` sequence is 0x0010, 0x0012, 0x0014, with `instr_valid` continuously 1 after the first fetch.
- `ready` low for 3 cycles at addr 0x0004 → `imem_addr` stays 0x0004 for 4 cycles, `instr_valid` is 0 for 3 cycles, then `instr_pc` = 0x0004 with the correct word.
- `stall` high for 2 cycles while instr 0x1234 is presented → `instr` = 0x1234 held, `req` = 0 during stall, fetch resumes at the next PC.
- `redirect` with `redirect_pc` = 0x0101 while `stall` = 1 → `instr_valid` = 0 next cycle; next fetch address is 0x0100.
- PC at 0xFFFE, zero-wait memory → next `instr_pc` = 0x0000.
- `halt_sys` pulsed 1 cycle with `redirect` also high → `halted` = 1 next cycle, `req` stays 0 indefinitely, redirect ignored; async `rst_n` low mid-HALTED → all outputs at reset values immediately.
